countdown_timer: RTL

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer_if.sv | 35 +++
 rtl/countdown_timer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/countdown_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer_if
//  Description : Signal bundle between a game controller and countdown_timer.
//                Carries the load/run/penalty controls towards the timer and
//                the remaining-time, state and alarm indications back.
//  Modports    : master - controller side (drives controls, reads status)
//                slave  - timer side (reads controls, drives status)
//  Revision    : 1.0 - initial release
// ============================================================================
interface countdown_timer_if;
    logic        load;
    logic [4:0]  load_minutes;
    logic [5:0]  load_seconds;
    logic        run;
    logic        penalty;
    logic [10:0] remaining;
    logic [4:0]  minutes;
    logic [5:0]  seconds;
    logic [1:0]  state;
    logic        warning;
    logic        expired;
    logic        expire_pulse;

    modport master (
        output load, load_minutes, load_seconds, run, penalty,
        input  remaining, minutes, seconds, state, warning, expired, expire_pulse
    );

    modport slave (
        input  load, load_minutes, load_seconds, run, penalty,
        output remaining, minutes, seconds, state, warning, expired, expire_pulse
    );
endinterface
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer
//  Description : Game clock ticking at 1 Hz. A loaded budget (mm:ss, clamped)
//                counts down while run is high; a penalty removes extra
//                seconds. Reaching zero enters EXPIRED with a one-cycle pulse.
//  Ports       : clk_1Hz      - one-second tick clock (rising edge)
//                reset        - asynchronous, active-high
//                bus (slave)  - load, load_minutes, load_seconds, run, penalty
//                               in; remaining, minutes, seconds, state,
//                               warning, expired, expire_pulse out
//  Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer #(
    parameter int MAX_MINUTES     = 30,
    parameter int WARN_SECONDS    = 60,
    parameter int PENALTY_SECONDS = 10
) (
    input  wire logic          clk_1Hz,
    input  wire logic          reset,
    countdown_timer_if.slave   bus
);

    localparam logic [1:0]  c_IDLE    = 2'd0;
    localparam logic [1:0]  c_PAUSED  = 2'd1;
    localparam logic [1:0]  c_RUNNING = 2'd2;
    localparam logic [1:0]  c_EXPIRED = 2'd3;

    localparam logic [4:0]  c_MAX_MIN = 5'(MAX_MINUTES);
    localparam logic [10:0] c_WARN    = 11'(WARN_SECONDS);
    localparam logic [10:0] c_PEN     = 11'(PENALTY_SECONDS);
    localparam logic [5:0]  c_PEN_S   = 6'(PENALTY_SECONDS);

    logic [1:0]  r_state;
    logic [10:0] r_remaining;
    logic [4:0]  r_minutes;
    logic [5:0]  r_seconds;
    logic        r_warning;
    logic        r_expire_pulse;

    logic [1:0]  w_nxt_state;
    logic [10:0] w_nxt_rem;
    logic [4:0]  w_nxt_min;
    logic [5:0]  w_nxt_sec;
    logic        w_nxt_warn;
    logic        w_nxt_pulse;

    // Clamped load budget. Over-range minutes pin the budget to MAX:00.
    logic        w_min_over;
    logic [4:0]  w_ld_min;
    logic [5:0]  w_ld_sec;
    logic [10:0] w_ld_rem;

    assign w_min_over = (bus.load_minutes > c_MAX_MIN);
    assign w_ld_min   = w_min_over ? c_MAX_MIN : bus.load_minutes;
    assign w_ld_sec   = w_min_over ? 6'd0
                      : ((bus.load_seconds > 6'd59) ? 6'd59 : bus.load_seconds);
    assign w_ld_rem   = {6'd0, w_ld_min} * 11'd60 + {5'd0, w_ld_sec};

    // Seconds removed on a running tick (at most 60, so one borrow suffices).
    logic [10:0] w_dec;
    logic [5:0]  w_dec_s;

    assign w_dec   = bus.penalty ? (11'd1 + c_PEN)   : 11'd1;
    assign w_dec_s = bus.penalty ? (6'd1  + c_PEN_S) : 6'd1;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_rem   = r_remaining;
        w_nxt_min   = r_minutes;
        w_nxt_sec   = r_seconds;
        w_nxt_pulse = 1'b0;

        if (bus.load) begin
            if (w_ld_rem == 11'd0) begin
                w_nxt_state = c_EXPIRED;
                w_nxt_rem   = 11'd0;
                w_nxt_min   = 5'd0;
                w_nxt_sec   = 6'd0;
                w_nxt_pulse = 1'b1;
            end else begin
                w_nxt_state = c_PAUSED;
                w_nxt_rem   = w_ld_rem;
                w_nxt_min   = w_ld_min;
                w_nxt_sec   = w_ld_sec;
            end
        end else begin
            case (r_state)
                c_PAUSED: begin
                    if (bus.run) begin
                        w_nxt_state = c_RUNNING;
                    end
                end
                c_RUNNING: begin
                    if (!bus.run) begin
                        w_nxt_state = c_PAUSED;
                    end else if (r_remaining > w_dec) begin
                        w_nxt_rem = r_remaining - w_dec;
                        // mm:ss tracked alongside the total so no divider is
                        // needed; remaining > dec guarantees minutes >= 1 on borrow.
                        if (r_seconds >= w_dec_s) begin
                            w_nxt_sec = r_seconds - w_dec_s;
                        end else begin
                            w_nxt_min = r_minutes - 5'd1;
                            w_nxt_sec = r_seconds + 6'd60 - w_dec_s;
                        end
                    end else begin
                        w_nxt_state = c_EXPIRED;
                        w_nxt_rem   = 11'd0;
                        w_nxt_min   = 5'd0;
                        w_nxt_sec   = 6'd0;
                        w_nxt_pulse = 1'b1;
                    end
                end
                default: begin
                    // IDLE and EXPIRED both hold a zero budget.
                    w_nxt_rem = 11'd0;
                    w_nxt_min = 5'd0;
                    w_nxt_sec = 6'd0;
                end
            endcase
        end

        w_nxt_warn = ((w_nxt_state == c_PAUSED) || (w_nxt_state == c_RUNNING))
                   && (w_nxt_rem != 11'd0) && (w_nxt_rem <= c_WARN);
    end

    always_ff @(posedge clk_1Hz or posedge reset) begin
        if (reset) begin
            r_state        <= c_IDLE;
            r_remaining    <= 11'd0;
            r_minutes      <= 5'd0;
            r_seconds      <= 6'd0;
            r_warning      <= 1'b0;
            r_expire_pulse <= 1'b0;
        end else begin
            r_state        <= w_nxt_state;
            r_remaining    <= w_nxt_rem;
            r_minutes      <= w_nxt_min;
            r_seconds      <= w_nxt_sec;
            r_warning      <= w_nxt_warn;
            r_expire_pulse <= w_nxt_pulse;
        end
    end

    assign bus.state        = r_state;
    assign bus.remaining    = r_remaining;
    assign bus.minutes      = r_minutes;
    assign bus.seconds      = r_seconds;
    assign bus.warning      = r_warning;
    assign bus.expired      = (r_state == c_EXPIRED);
    assign bus.expire_pulse = r_expire_pulse;

endmodule
`default_nettype wire
